tft_pixel_feeder: RTL and testbench
===================================

Name: tft_pixel_feeder

Overview:
- Upstream write-path stage for the TFT/SDRAM display controller. Supplies the controller's user write address (`page_set`, `row_add_user`, `col_add_user`), write data and `startup`.
- After reset, sweeps every SDRAM frame page with CLEAR_COLOR, then asserts `startup`.
- In user mode, buffers host pixels in a small show-ahead FIFO. Writes them at an auto-incrementing cursor, advancing one word per controller write-commit pulse.

Parameters:
- H_ACT, 800, active columns per line (col 0..H_ACT-1)
- V_ACT, 480, active rows per page (row 0..V_ACT-1)
- NUM_PAGES, 8, frame pages swept by the clear phase (page 0..NUM_PAGES-1)
- DEPTH, 4, pixel FIFO depth in words (power of two)
- CLEAR_COLOR, 16'h0000, RGB565 word written during the clear phase

Ports:
- clk  in  1  system clock (SDRAM controller clock)
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  host cursor-set request
- cmd_ready  out  1  cursor-set accepted when cmd_valid & cmd_ready
- cmd_page  in  3  target page
- cmd_row  in  9  start row
- cmd_col  in  10  start column
- pix_valid  in  1  host pixel valid
- pix_ready  out  1  FIFO not full and startup=1
- pix_data  in  16  RGB565 pixel
- wr_inc  in  1  one-cycle pulse from controller: one word committed to SDRAM
- fifo_rd_req  in  1  controller pop request
- fifo_full  out  1  drives controller FIFO_full input: 1 = at least one word available
- fifo_out  out  16  head word (show-ahead)
- page_set  out  3  write page
- row_add_user  out  9  write row
- col_add_user  out  10  write column
- startup  out  1  0 = clear phase, 1 = user phase
- clear_done  out  1  one-cycle pulse when the clear phase completes

Behaviour:
- Reset values:
  - `startup`=0, `clear_done`=0, `fifo_full`=0, `fifo_out`=CLEAR_COLOR.
  - `page_set`=0, `row_add_user`=0, `col_add_user`=0.
  - `cmd_ready`=0, `pix_ready`=0; FIFO emptied.
- FSM has states CLEAR, RUN.
- CLEAR:
  - `fifo_out`=CLEAR_COLOR; `fifo_full`=0; `pix_ready`=0; `cmd_ready`=0; `fifo_rd_req` ignored.
  - Each `wr_inc` advances the cursor in the order col, then row, then page.
  - `wr_inc` while cursor is (NUM_PAGES-1, V_ACT-1, H_ACT-1): cursor goes to (0,0,0) and `startup` goes to 1 on the next edge.
  - The same edge pulses `clear_done` for one cycle; state goes to RUN.
  - No other exit from CLEAR.
- RUN cursor advance, on `wr_inc`:
  - col+1.
  - At col=H_ACT-1: col=0, row+1.
  - At row=V_ACT-1 and col=H_ACT-1: row=0, col=0, page unchanged (wraps within the page).
- RUN cursor set:
  - `cmd_ready` = FIFO empty & !`wr_inc`.
  - On accept, cursor loads {`cmd_page`, `cmd_row`, `cmd_col`} at the next edge.
  - `cmd_row` >= V_ACT clamps to V_ACT-1; `cmd_col` >= H_ACT clamps to H_ACT-1.
- FIFO:
  - Push on `pix_valid` & `pix_ready`.
  - Pop on `fifo_rd_req` & !empty; `fifo_rd_req` on empty is ignored with no underflow.
  - Simultaneous push and pop while full is allowed: count is unchanged and `pix_ready` stays 1.
  - `fifo_out` = storage[rd_ptr], valid while `fifo_full`=1.
  - Latency is one cycle from push edge to `fifo_full`=1.
  - Count width is log2(DEPTH)+1; pointers wrap modulo DEPTH.
- Ordering: the cursor is not advanced by `fifo_rd_req`, only by `wr_inc`.
- Reset mid-operation: everything returns to CLEAR and the clear sweep restarts from page 0; buffered pixels are discarded.

Decomposition:
- Shared package `tft_pkg`:
  - Constants H_ACT, V_ACT, NUM_PAGES, CLEAR_COLOR.
  - Address widths: PAGE_W=3, ROW_W=9, COL_W=10.
  - Pixel width: PIX_W=16.
  - FSM state enum {CLEAR, RUN}.
- One natural sub-module: `tft_pix_fifo`, a synchronous show-ahead FIFO with push/pop/count/empty/full.
- Cursor counter and FSM stay in the top level.

Test Plan:
- Reset release, then `wr_inc` every 2 cycles (small bench params: H_ACT=4, V_ACT=2, NUM_PAGES=2):
  - `startup`=0 and `fifo_out`=0000 throughout CLEAR.
  - Cursor visits (0,0,0)..(1,1,3) in order.
  - After the 16th `wr_inc`, `startup`=1, `clear_done` pulses once, cursor=(0,0,0).
- In RUN, push 5 words A0..A4 with no pops (DEPTH=4):
  - `pix_ready` drops after 4 pushes; A4 is held.
  - `fifo_out`=A0; after one pop, `fifo_out`=A1 and `pix_ready`=1.
- Cursor set page 5, row 1, col 3 (bench dims), then 2 `wr_inc`:
  - Cursor (5,1,3) becomes (5,0,0), then (5,0,1).
- `cmd_valid` with 1 word in the FIFO:
  - `cmd_ready`=0, cursor unchanged.
  - After pop, `cmd_ready`=1 and the command is accepted.
- Push and pop in the same cycle while full: count stays 4 and the order is preserved (B0 out, B4 appended at tail).
- Assert `rst`=0 mid-RUN with 3 words buffered: `startup`=0, `fifo_full`=0, cursor=(0,0,0), and the CLEAR sweep restarts.

Source files
------------

// File: rtl/tft_pixel_feeder_pkg.sv
// rtl/tft_pixel_feeder_pkg.sv - shared constants, widths and FSM state for the TFT pixel feeder
package tft_pkg;
    localparam int H_ACT     = 800;
    localparam int V_ACT     = 480;
    localparam int NUM_PAGES = 8;

    localparam int PAGE_W = 3;
    localparam int ROW_W  = 9;
    localparam int COL_W  = 10;
    localparam int PIX_W  = 16;

    localparam logic [PIX_W-1:0] CLEAR_COLOR = 16'h0000;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;
endpackage

// File: rtl/tft_pixel_feeder_if.sv
// rtl/tft_pixel_feeder_if.sv - host cursor-set and pixel handshakes into the feeder
interface tft_pixel_feeder_if;
    import tft_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [PAGE_W-1:0] cmd_page;
    logic [ROW_W-1:0]  cmd_row;
    logic [COL_W-1:0]  cmd_col;
    logic              pix_valid;
    logic              pix_ready;
    logic [PIX_W-1:0]  pix_data;

    modport master (
        output cmd_valid, cmd_page, cmd_row, cmd_col, pix_valid, pix_data,
        input  cmd_ready, pix_ready
    );

    modport slave (
        input  cmd_valid, cmd_page, cmd_row, cmd_col, pix_valid, pix_data,
        output cmd_ready, pix_ready
    );
endinterface

// File: rtl/tft_pix_fifo.sv
// rtl/tft_pix_fifo.sv - synchronous show-ahead FIFO; a push into a full FIFO is taken when a pop frees the slot
module tft_pix_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/tft_pixel_feeder.sv
// rtl/tft_pixel_feeder.sv - clears every SDRAM page, then feeds host pixels at an auto-incrementing cursor
module tft_pixel_feeder
    import tft_pkg::*;
#(
    parameter int               H_ACT       = tft_pkg::H_ACT,
    parameter int               V_ACT       = tft_pkg::V_ACT,
    parameter int               NUM_PAGES   = tft_pkg::NUM_PAGES,
    parameter int               DEPTH       = 4,
    parameter logic [PIX_W-1:0] CLEAR_COLOR = tft_pkg::CLEAR_COLOR
) (
    input  logic                clk,
    input  logic                rst,
    tft_pixel_feeder_if.slave   host,
    input  logic                wr_inc,
    input  logic                fifo_rd_req,
    output logic                fifo_full,
    output logic [PIX_W-1:0]    fifo_out,
    output logic [PAGE_W-1:0]   page_set,
    output logic [ROW_W-1:0]    row_add_user,
    output logic [COL_W-1:0]    col_add_user,
    output logic                startup,
    output logic                clear_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(H_ACT - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(V_ACT - 1);
    localparam logic [PAGE_W-1:0] PAGE_LAST = PAGE_W'(NUM_PAGES - 1);

    state_t            state, state_nxt;
    logic [PAGE_W-1:0] page_nxt;
    logic [ROW_W-1:0]  row_nxt;
    logic [COL_W-1:0]  col_nxt;
    logic              done_nxt;
    logic              run;
    logic              push, pop, empty, full;
    logic [PIX_W-1:0]  head;
    logic [AW:0]       fifo_count;
    logic              cmd_fire, line_end, page_end, sweep_end;

    assign run            = (state == RUN);
    assign startup        = run;
    assign pop            = run & fifo_rd_req & ~empty;
    assign host.pix_ready = run & (~full | pop);
    assign push           = host.pix_valid & host.pix_ready;
    assign host.cmd_ready = run & (fifo_count == '0) & ~wr_inc;
    assign cmd_fire       = host.cmd_valid & host.cmd_ready;
    assign fifo_full      = run & ~empty;
    assign fifo_out       = run ? head : CLEAR_COLOR;

    assign line_end  = (col_add_user == COL_LAST);
    assign page_end  = line_end & (row_add_user == ROW_LAST);
    assign sweep_end = page_end & (page_set == PAGE_LAST);

    tft_pix_fifo #(.WIDTH(PIX_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (host.pix_data),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count),
        .empty     (empty),
        .full      (full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= CLEAR;
            page_set     <= '0;
            row_add_user <= '0;
            col_add_user <= '0;
            clear_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            page_set     <= page_nxt;
            row_add_user <= row_nxt;
            col_add_user <= col_nxt;
            clear_done   <= done_nxt;
        end
    end

    // cmd_ready excludes wr_inc, so a cursor load and an advance never collide
    always_comb begin
        state_nxt = state;
        page_nxt  = page_set;
        row_nxt   = row_add_user;
        col_nxt   = col_add_user;
        done_nxt  = 1'b0;
        if (cmd_fire) begin
            page_nxt = host.cmd_page;
            row_nxt  = (host.cmd_row > ROW_LAST) ? ROW_LAST : host.cmd_row;
            col_nxt  = (host.cmd_col > COL_LAST) ? COL_LAST : host.cmd_col;
        end else if (wr_inc) begin
            col_nxt = line_end ? '0 : col_add_user + 1'b1;
            if (line_end) begin
                row_nxt = (row_add_user == ROW_LAST) ? '0 : row_add_user + 1'b1;
            end
            // only the clear sweep crosses pages; user writes wrap within their page
            if (!run && page_end) begin
                page_nxt = sweep_end ? '0 : page_set + 1'b1;
            end
            if (!run && sweep_end) begin
                state_nxt = RUN;
                done_nxt  = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_tft_pixel_feeder.sv
// tb/tb_tft_pixel_feeder.sv - scoreboard bench for the TFT pixel feeder with small frame dimensions
module tb_tft_pixel_feeder;
    import tft_pkg::*;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int NP = 2;
    localparam int D  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_inc;
    logic        fifo_rd_req;
    logic        fifo_full;
    logic [15:0] fifo_out;
    logic [2:0]  page_set;
    logic [8:0]  row_add_user;
    logic [9:0]  col_add_user;
    logic        startup;
    logic        clear_done;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] sb [$];

    always #5 clk = ~clk;

    tft_pixel_feeder_if hif ();

    tft_pixel_feeder #(
        .H_ACT       (H),
        .V_ACT       (V),
        .NUM_PAGES   (NP),
        .DEPTH       (D),
        .CLEAR_COLOR (16'h0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .host         (hif),
        .wr_inc       (wr_inc),
        .fifo_rd_req  (fifo_rd_req),
        .fifo_full    (fifo_full),
        .fifo_out     (fifo_out),
        .page_set     (page_set),
        .row_add_user (row_add_user),
        .col_add_user (col_add_user),
        .startup      (startup),
        .clear_done   (clear_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cv(input int p, input int r, input int c);
        return {10'b0, 3'(p), 9'(r), 10'(c)};
    endfunction

    function automatic logic [31:0] cur();
        return {10'b0, page_set, row_add_user, col_add_user};
    endfunction

    task automatic push_one(input logic [15:0] d);
        hif.pix_valid = 1'b1;
        hif.pix_data  = d;
        #1;
        check("push ready", hif.pix_ready, 1);
        if (hif.pix_ready) sb.push_back(d);
        tick();
        hif.pix_valid = 1'b0;
        #1;
        check("push visible", fifo_full, 1);
    endtask

    task automatic pop_one(input string tag);
        check({tag, " valid"}, fifo_full, 1);
        check({tag, " data"}, fifo_out, sb[0]);
        fifo_rd_req = 1'b1;
        tick();
        fifo_rd_req = 1'b0;
        void'(sb.pop_front());
        #1;
    endtask

    task automatic step_wr;
        wr_inc = 1'b1;
        tick();
        wr_inc = 1'b0;
        #1;
    endtask

    initial begin
        rst           = 1'b0;
        wr_inc        = 1'b0;
        fifo_rd_req   = 1'b0;
        hif.cmd_valid = 1'b0;
        hif.cmd_page  = '0;
        hif.cmd_row   = '0;
        hif.cmd_col   = '0;
        hif.pix_valid = 1'b0;
        hif.pix_data  = '0;
        tick();
        tick();

        check("rst startup", startup, 0);
        check("rst clear_done", clear_done, 0);
        check("rst fifo_full", fifo_full, 0);
        check("rst fifo_out", fifo_out, 16'h0000);
        check("rst cursor", cur(), cv(0, 0, 0));
        check("rst cmd_ready", hif.cmd_ready, 0);
        check("rst pix_ready", hif.pix_ready, 0);

        rst = 1'b1;
        tick();

        for (int i = 0; i < H * V * NP; i++) begin
            check("clr cursor", cur(), cv(i / (H * V), (i / H) % V, i % H));
            check("clr startup", startup, 0);
            check("clr fifo_out", fifo_out, 16'h0000);
            check("clr pix_ready", hif.pix_ready, 0);
            check("clr cmd_ready", hif.cmd_ready, 0);
            wr_inc = 1'b1;
            tick();
            wr_inc = 1'b0;
            check("clr done pulse", clear_done, (i == H * V * NP - 1));
            tick();
        end
        check("clr done once", clear_done, 0);
        check("run startup", startup, 1);
        check("run cursor", cur(), cv(0, 0, 0));

        // fill past capacity: the fifth word must be held back
        for (int i = 0; i < 5; i++) begin
            hif.pix_valid = 1'b1;
            hif.pix_data  = 16'(16'hA0 + i);
            #1;
            check("fill ready", hif.pix_ready, (i < D));
            if (hif.pix_ready) sb.push_back(hif.pix_data);
            tick();
            check("fill fifo_full", fifo_full, 1);
        end
        hif.pix_valid = 1'b0;
        #1;
        check("full ready", hif.pix_ready, 0);
        pop_one("A0");
        check("ready after pop", hif.pix_ready, 1);
        while (sb.size() > 0) pop_one("A drain");
        check("drained", fifo_full, 0);

        fifo_rd_req = 1'b1;
        tick();
        fifo_rd_req = 1'b0;
        #1;
        check("underflow empty", fifo_full, 0);
        push_one(16'h1234);
        pop_one("post underflow");
        check("post underflow empty", fifo_full, 0);

        hif.cmd_valid = 1'b1;
        hif.cmd_page  = 3'd5;
        hif.cmd_row   = 9'd1;
        hif.cmd_col   = 10'd3;
        #1;
        check("cmd_ready idle", hif.cmd_ready, 1);
        tick();
        hif.cmd_valid = 1'b0;
        check("cursor set", cur(), cv(5, 1, 3));
        step_wr();
        check("wrap in page", cur(), cv(5, 0, 0));

        hif.cmd_valid = 1'b1;
        hif.cmd_page  = 3'd7;
        hif.cmd_row   = 9'd1;
        hif.cmd_col   = 10'd1;
        wr_inc        = 1'b1;
        #1;
        check("cmd_ready wr_inc", hif.cmd_ready, 0);
        tick();
        wr_inc        = 1'b0;
        hif.cmd_valid = 1'b0;
        check("advance", cur(), cv(5, 0, 1));

        hif.cmd_valid = 1'b1;
        hif.cmd_page  = 3'd2;
        hif.cmd_row   = 9'd300;
        hif.cmd_col   = 10'd900;
        tick();
        hif.cmd_valid = 1'b0;
        check("clamp", cur(), cv(2, V - 1, H - 1));

        push_one(16'hC0C0);
        hif.cmd_valid = 1'b1;
        hif.cmd_page  = 3'd3;
        hif.cmd_row   = 9'd0;
        hif.cmd_col   = 10'd2;
        #1;
        check("cmd_ready busy", hif.cmd_ready, 0);
        tick();
        check("cmd blocked", cur(), cv(2, V - 1, H - 1));
        pop_one("C0");
        check("cmd_ready after pop", hif.cmd_ready, 1);
        check("pop keeps cursor", cur(), cv(2, V - 1, H - 1));
        tick();
        hif.cmd_valid = 1'b0;
        check("cmd accepted", cur(), cv(3, 0, 2));

        for (int i = 0; i < D; i++) push_one(16'(16'hB0 + i));
        #1;
        check("B full", hif.pix_ready, 0);
        hif.pix_valid = 1'b1;
        hif.pix_data  = 16'hB4;
        fifo_rd_req   = 1'b1;
        #1;
        check("push+pop ready", hif.pix_ready, 1);
        check("push+pop head", fifo_out, sb[0]);
        void'(sb.pop_front());
        sb.push_back(16'hB4);
        tick();
        hif.pix_valid = 1'b0;
        fifo_rd_req   = 1'b0;
        #1;
        check("still full", hif.pix_ready, 0);
        while (sb.size() > 0) pop_one("B drain");
        check("B drained", fifo_full, 0);

        step_wr();
        check("pre-reset cursor", cur(), cv(3, 0, 3));
        for (int i = 0; i < 3; i++) push_one(16'(16'hC1 + i));
        rst = 1'b0;
        #1;
        check("mid rst startup", startup, 0);
        check("mid rst fifo_full", fifo_full, 0);
        check("mid rst cursor", cur(), cv(0, 0, 0));
        check("mid rst fifo_out", fifo_out, 16'h0000);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        step_wr();
        check("resweep cursor", cur(), cv(0, 0, 1));
        check("resweep startup", startup, 0);
        check("resweep discarded", fifo_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
